param_scfifo: RTL and testbench

//  Parametrised single-clock FIFO for buffering data words between producer and consumer logic
//  in one clock domain.

---
 rtl/param_scfifo_pkg.sv | 42 ++++
 rtl/param_scfifo_sdp_ram.sv | 51 +++++
 rtl/param_scfifo.sv | 164 ++++++++++++++++
 tb/tb_param_scfifo.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/param_scfifo_pkg.sv
// Shared definitions for the parametrised single-clock FIFO: read-mode constants,
// the registered status-flag bundle and small elaboration helpers.
package param_scfifo_pkg;

  // Read-mode selectors for the SHOWAHEAD parameter.
  localparam int unsigned MODE_NORMAL    = 0;
  localparam int unsigned MODE_SHOWAHEAD = 1;

  // Level-derived status flags, registered together with the word counter.
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Derive every level flag from a word count so reset and run-time values share one rule.
  function automatic fifo_flags_t calc_flags(input int unsigned count,
                                             input int unsigned depth,
                                             input int unsigned af_level,
                                             input int unsigned ae_level);
    fifo_flags_t f;
    f.empty        = (count == 0);
    f.full         = (count == depth);
    f.almost_empty = (count < ae_level);
    f.almost_full  = (count >= af_level);
    return f;
  endfunction

endpackage

// File: rtl/param_scfifo_sdp_ram.sv
// Simple dual-port storage array: one synchronous write port and one read port that is
// either registered (with enable and synchronous clear) or purely combinational.
module param_scfifo_sdp_ram
  import param_scfifo_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned REG_RD = 1,
  localparam int unsigned ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: contents are never cleared, only overwritten.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  if (REG_RD != 0) begin : g_reg_rd
    logic [DATA_W-1:0] rd_data_q;

    // Registered read: the output holds until the next enabled read or a clear.
    always_ff @(posedge clk) begin
      if (rd_clr) begin
        rd_data_q <= '0;
      end else if (rd_en) begin
        rd_data_q <= mem[rd_addr];
      end
    end

    assign rd_data = rd_data_q;
  end else begin : g_comb_rd
    // Enable and clear have no meaning for an asynchronous read port.
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = rd_en ^ rd_clr;

    assign rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/param_scfifo.sv
// Parametrised single-clock FIFO with word counter, registered level flags, sticky
// overflow/underflow and a choice of normal or show-ahead read data.
module param_scfifo
  import param_scfifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned SHOWAHEAD = MODE_NORMAL,
  parameter int unsigned AF_LEVEL  = 240,
  parameter int unsigned AE_LEVEL  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              sclr,
  input  logic [DATA_W-1:0] data,
  input  logic              wrreq,
  input  logic              rdreq,
  output logic [DATA_W-1:0] q,
  output logic [ADDR_W:0]   usedw,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam fifo_flags_t FLAGS_RST = calc_flags(0, DEPTH, AF_LEVEL, AE_LEVEL);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   usedw_q, usedw_d;
  fifo_flags_t       flags_q, flags_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              clear;
  logic              wr_acc;
  logic              rd_acc;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;

  // Reset and sclr clear identically; requests in a clearing cycle are ignored.
  assign clear  = ~Rst_n | sclr;
  assign wr_acc = wrreq & ~flags_q.full;
  assign rd_acc = rdreq & ~flags_q.empty;

  // Next-state for pointers, counter, level flags and sticky error bits.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    usedw_d     = usedw_q;
    overflow_d  = overflow_q | (wrreq & flags_q.full);
    underflow_d = underflow_q | (rdreq & flags_q.empty);

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   usedw_d = usedw_q + CNT_ONE;
      2'b01:   usedw_d = usedw_q - CNT_ONE;
      default: usedw_d = usedw_q;
    endcase

    // Flags follow the new count on the same edge as the counter.
    flags_d = calc_flags(32'(usedw_d), DEPTH, AF_LEVEL, AE_LEVEL);
  end

  // State registers with synchronous clear.
  always_ff @(posedge Clk) begin
    if (clear) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      usedw_q     <= '0;
      flags_q     <= FLAGS_RST;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      usedw_q     <= usedw_d;
      flags_q     <= flags_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Show-ahead looks one word past the head so the register can advance on a pop.
  assign ram_rd_addr = (SHOWAHEAD == MODE_SHOWAHEAD) ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

  param_scfifo_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .REG_RD ((SHOWAHEAD == MODE_SHOWAHEAD) ? 0 : 1)
  ) u_ram (
    .clk     (Clk),
    .wr_en   (wr_acc & ~clear),
    .wr_addr (wr_ptr_q),
    .wr_data (data),
    .rd_en   (rd_acc & ~clear),
    .rd_clr  (clear),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  if (SHOWAHEAD == MODE_SHOWAHEAD) begin : g_showahead
    logic [DATA_W-1:0] q_q, q_d;

    // Head-word register: loads the incoming word when it becomes (or replaces) the head,
    // otherwise the RAM word following the current head.
    always_comb begin
      q_d = q_q;
      if (rd_acc) begin
        if (usedw_q == CNT_ONE) begin
          // Last stored word is leaving; only a simultaneous write yields a new head.
          if (wr_acc) begin
            q_d = data;
          end
        end else begin
          q_d = ram_rd_data;
        end
      end else if (flags_q.empty && wr_acc) begin
        q_d = data;
      end
    end

    // Head-word register update.
    always_ff @(posedge Clk) begin
      if (clear) begin
        q_q <= '0;
      end else begin
        q_q <= q_d;
      end
    end

    assign q = q_q;
  end else begin : g_normal
    assign q = ram_rd_data;
  end

  assign usedw        = usedw_q;
  assign empty        = flags_q.empty;
  assign full         = flags_q.full;
  assign almost_empty = flags_q.almost_empty;
  assign almost_full  = flags_q.almost_full;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Internal consistency checks.
  a_usedw_range: assert property (@(posedge Clk) disable iff (!Rst_n)
    usedw_q <= (ADDR_W + 1)'(DEPTH));
  a_empty_full_excl: assert property (@(posedge Clk) disable iff (!Rst_n)
    !(flags_q.empty && flags_q.full));
  a_ptr_gap: assert property (@(posedge Clk) disable iff (!Rst_n)
    (wr_ptr_q - rd_ptr_q) == usedw_q[ADDR_W-1:0]);

endmodule

// File: tb/tb_param_scfifo.sv
// Self-checking bench: a normal-mode and a show-ahead instance share one stimulus stream
// and are compared every cycle against a queue-based model of the FIFO.
module tb_param_scfifo;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int AF    = 240;
  localparam int AE    = 16;

  logic          clk = 1'b0;
  logic          rst_n, sclr, wrreq, rdreq;
  logic [DW-1:0] data;

  logic [DW-1:0] q_n, q_s;
  logic [AW:0]   usedw_n, usedw_s;
  logic          empty_n, full_n, ae_n, af_n, ovf_n, unf_n;
  logic          empty_s, full_s, ae_s, af_s, ovf_s, unf_s;

  always #5 clk = ~clk;

  param_scfifo #(
    .DATA_W (DW), .ADDR_W (AW), .SHOWAHEAD (0), .AF_LEVEL (AF), .AE_LEVEL (AE)
  ) dut_n (
    .Clk (clk), .Rst_n (rst_n), .sclr (sclr), .data (data), .wrreq (wrreq), .rdreq (rdreq),
    .q (q_n), .usedw (usedw_n), .empty (empty_n), .full (full_n), .almost_empty (ae_n),
    .almost_full (af_n), .overflow (ovf_n), .underflow (unf_n)
  );

  param_scfifo #(
    .DATA_W (DW), .ADDR_W (AW), .SHOWAHEAD (1), .AF_LEVEL (AF), .AE_LEVEL (AE)
  ) dut_s (
    .Clk (clk), .Rst_n (rst_n), .sclr (sclr), .data (data), .wrreq (wrreq), .rdreq (rdreq),
    .q (q_s), .usedw (usedw_s), .empty (empty_s), .full (full_s), .almost_empty (ae_s),
    .almost_full (af_s), .overflow (ovf_s), .underflow (unf_s)
  );

  // Reference model: stored words, last popped word, sticky errors.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_q;
  bit            m_ovf, m_unf;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_update();
    bit w, r;
    if (!rst_n || sclr) begin
      mq.delete();
      m_q   = '0;
      m_ovf = 0;
      m_unf = 0;
    end else begin
      w = wrreq && (mq.size() < DEPTH);
      r = rdreq && (mq.size() > 0);
      if (wrreq && mq.size() == DEPTH) m_ovf = 1;
      if (rdreq && mq.size() == 0) m_unf = 1;
      if (r) m_q = mq.pop_front();
      if (w) mq.push_back(data);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = mq.size();
    chk("usedw_n", 32'(usedw_n), 32'(sz));
    chk("usedw_s", 32'(usedw_s), 32'(sz));
    chk("empty_n", 32'(empty_n), 32'(sz == 0));
    chk("empty_s", 32'(empty_s), 32'(sz == 0));
    chk("full_n", 32'(full_n), 32'(sz == DEPTH));
    chk("full_s", 32'(full_s), 32'(sz == DEPTH));
    chk("almost_empty", 32'({ae_n, ae_s}), {30'd0, {2{sz < AE}}});
    chk("almost_full", 32'({af_n, af_s}), {30'd0, {2{sz >= AF}}});
    chk("overflow", 32'({ovf_n, ovf_s}), {30'd0, {2{m_ovf}}});
    chk("underflow", 32'({unf_n, unf_s}), {30'd0, {2{m_unf}}});
    chk("q_normal", 32'(q_n), 32'(m_q));
    if (sz > 0) chk("q_showahead", 32'(q_s), 32'(mq[0]));
  endtask

  task automatic drive(input logic r, input logic s, input logic w, input logic rd,
                       input logic [DW-1:0] d);
    rst_n = r; sclr = s; wrreq = w; rdreq = rd; data = d;
  endtask

  // One clock: model follows the edge, then both DUTs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  typedef struct {
    logic          sclr, wr, rd;
    logic [DW-1:0] d;
    int            usedw;
    logic          empty;
    logic [DW-1:0] qn;
    logic          qs_vld;
    logic [DW-1:0] qs;
    logic          unf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int exp_q;

    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Table of short accept/reject cases starting from an empty FIFO.
    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0011, 1, 1'b0, 16'h0000, 1'b1, 16'h0011, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0022, 2, 1'b0, 16'h0000, 1'b1, 16'h0011, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h0033, 2, 1'b0, 16'h0011, 1'b1, 16'h0022, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1, 1'b0, 16'h0022, 1'b1, 16'h0033, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b1, 16'h0033, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b1, 16'h0033, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 16'h0099, 0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 16'h0044, 1, 1'b0, 16'h0000, 1'b1, 16'h0044, 1'b1};

    // Reset state.
    repeat (2) step();
    chk("rst_usedw", 32'(usedw_n), 32'd0);
    chk("rst_empty", 32'(empty_n), 32'd1);
    chk("rst_full", 32'(full_n), 32'd0);
    chk("rst_ae_af", 32'({ae_n, af_n}), 32'b10);
    chk("rst_q", 32'(q_n), 32'd0);
    chk("rst_ovf_unf", 32'({ovf_n, unf_n}), 32'd0);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].sclr, vecs[i].wr, vecs[i].rd, vecs[i].d);
      step();
      chk($sformatf("vec%0d_usedw", i), 32'(usedw_n), 32'(vecs[i].usedw));
      chk($sformatf("vec%0d_empty", i), 32'(empty_s), 32'(vecs[i].empty));
      chk($sformatf("vec%0d_qn", i), 32'(q_n), 32'(vecs[i].qn));
      if (vecs[i].qs_vld) chk($sformatf("vec%0d_qs", i), 32'(q_s), 32'(vecs[i].qs));
      chk($sformatf("vec%0d_unf", i), 32'(unf_n), 32'(vecs[i].unf));
    end

    // Fill from empty: flag thresholds and full.
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, DW'(i));
      step();
      if (i == 14) chk("fill_ae_at15", 32'(ae_n), 32'd1);
      if (i == 15) chk("fill_ae_at16", 32'(ae_n), 32'd0);
      if (i == 238) chk("fill_af_at239", 32'(af_n), 32'd0);
      if (i == 239) chk("fill_af_at240", 32'(af_n), 32'd1);
    end
    chk("fill_full", 32'({full_n, full_s}), 32'b11);
    chk("fill_usedw", 32'(usedw_n), 32'd256);
    chk("fill_ovf", 32'(ovf_n), 32'd0);

    // Write while full is dropped and sets overflow.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'hDEAD);
    step();
    chk("ovf_set", 32'({ovf_n, ovf_s}), 32'b11);
    chk("ovf_usedw", 32'(usedw_n), 32'd256);

    // Drain: q returns 0..255 in order, one cycle after each rdreq.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, '0);
      step();
      chk("drain_q", 32'(q_n), 32'(i));
    end
    chk("drain_empty", 32'(empty_n), 32'd1);
    chk("drain_usedw", 32'(usedw_n), 32'd0);
    chk("drain_unf", 32'(unf_n), 32'd0);
    chk("drain_ovf_sticky", 32'(ovf_n), 32'd1);

    // 200 words then 300 simultaneous read/write cycles across the pointer wrap.
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step();
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, DW'(1000 + i));
      step();
    end
    for (int j = 0; j < 300; j++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, DW'(3000 + j));
      step();
      exp_q = (j < 200) ? 1000 + j : 3000 + (j - 200);
      chk("wrap_usedw", 32'(usedw_n), 32'd200);
      chk("wrap_q", 32'(q_n), 32'(exp_q));
    end

    // Show-ahead: single write into empty FIFO, then pop.
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h1234);
    step();
    chk("sa_empty", 32'(empty_s), 32'd0);
    chk("sa_q", 32'(q_s), 32'h1234);
    drive(1'b1, 1'b0, 1'b0, 1'b1, '0);
    step();
    chk("sa_pop_empty", 32'(empty_s), 32'd1);
    chk("sa_pop_usedw", 32'(usedw_s), 32'd0);
    step();  // rdreq while empty
    chk("unf_set", 32'(unf_n), 32'd1);

    // Mid-burst sclr with both requests active.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, DW'(16'h5000 + i));
      step();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h5555);
    step();
    chk("sclr_usedw", 32'(usedw_n), 32'd0);
    chk("sclr_empty", 32'({empty_n, empty_s}), 32'b11);
    chk("sclr_errs", 32'({ovf_n, unf_n}), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, '0);
    step();
    chk("unf_after_sclr", 32'(unf_n), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    step();
    chk("rst_clears_unf", 32'(unf_n), 32'd0);
    chk("rst_empty2", 32'(empty_n), 32'd1);

    // Randomised phases with varying write/read bias.
    for (int p = 0; p < 6; p++) begin
      int wp, rp;
      wp = (p % 3 == 0) ? 90 : (p % 3 == 1) ? 15 : 55;
      rp = (p % 3 == 0) ? 20 : (p % 3 == 1) ? 85 : 50;
      for (int c = 0; c < 500; c++) begin
        drive(($urandom_range(0, 599) != 0), ($urandom_range(0, 399) == 0),
              ($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp), DW'($urandom));
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
